// File: rtl/mux_arb.sv
// N-channel registered multiplexer with valid/ready handshaking and explicit-select arbitration.
// Optional round-robin arbitration is compiled in with `define MUX_ARB_RR_EN.
module mux_arb #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      mode,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          out_chan
);

    logic                r_out_valid;
    logic [WIDTH-1:0]    r_out_data;
    logic [SEL_W-1:0]    r_out_chan;

    logic                w_load_en;
    logic                w_sel_elig;
    logic                w_elig;
    logic                w_xfer;
    logic                w_rr;
    logic [SEL_W-1:0]    w_cand;
    logic [WIDTH-1:0]    w_cand_data;
    logic [CHANNELS-1:0] w_grant;
    logic [WIDTH-1:0]    w_chan_data [CHANNELS];

    for (genvar g = 0; g < CHANNELS; g++) begin : g_unpack
        assign w_chan_data[g] = in_data[g*WIDTH +: WIDTH];
    end

    assign w_load_en = !r_out_valid || out_ready;

    // Loop compare keeps sel >= CHANNELS from ever indexing in_valid out of range.
    always_comb begin
        w_sel_elig = 1'b0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (sel == SEL_W'(i) && in_valid[SEL_W'(i)]) begin
                w_sel_elig = 1'b1;
            end
        end
    end

`ifdef MUX_ARB_RR_EN
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] w_ptr_nxt;
    logic [SEL_W-1:0] w_idx;
    logic [SEL_W-1:0] w_rr_cand;
    logic             w_rr_found;

    assign w_rr = mode;

    always_comb begin
        w_rr_found = 1'b0;
        w_rr_cand  = '0;
        w_idx      = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            w_idx = SEL_W'((32'(r_ptr) + k) % CHANNELS);
            if (!w_rr_found && in_valid[w_idx]) begin
                w_rr_found = 1'b1;
                w_rr_cand  = w_idx;
            end
        end
    end

    assign w_ptr_nxt = (32'(w_cand) == CHANNELS - 1) ? '0 : w_cand + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_xfer && w_rr) begin
            r_ptr <= w_ptr_nxt;
        end
    end
`else
    logic w_unused_mode;

    assign w_rr          = 1'b0;
    assign w_unused_mode = mode;
`endif

    always_comb begin
        w_cand = sel;
        w_elig = w_sel_elig;
`ifdef MUX_ARB_RR_EN
        if (w_rr) begin
            w_cand = w_rr_cand;
            w_elig = w_rr_found;
        end
`endif
    end

    always_comb begin
        w_grant = '0;
        if (!rst && w_load_en && w_elig) begin
            w_grant[w_cand] = 1'b1;
        end
    end

    assign w_xfer      = |(w_grant & in_valid);
    assign w_cand_data = w_chan_data[w_cand];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_cand_data;
            r_out_chan  <= w_cand;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_grant;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;

endmodule

// File: tb/tb_mux_arb.sv
// Self-checking bench for mux_arb (WIDTH=8, CHANNELS=4): directed scenarios plus random traffic
// against a behavioural model; expectations follow MUX_ARB_RR_EN when it is defined.
module tb_mux_arb;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int SW = 2;
`ifdef MUX_ARB_RR_EN
    localparam bit RR_BUILT = 1'b1;
`else
    localparam bit RR_BUILT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [N*W-1:0] in_data;
    logic [N-1:0]  in_valid;
    logic [N-1:0]  in_ready;
    logic [SW-1:0] sel;
    logic          mode;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] out_chan;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: output register contents and round-robin start point.
    bit       m_valid;
    logic [7:0] m_data;
    int       m_chan;
    int       m_ptr;

    mux_arb #(.WIDTH(W), .CHANNELS(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sel      (sel),
        .mode     (mode),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_chan (out_chan)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Channel the rules say wins this cycle, or -1 for no grant.
    function automatic int model_grant();
        if (m_valid && !out_ready) return -1;
        if (RR_BUILT && mode) begin
            for (int k = 0; k < N; k++) begin
                if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
            end
            return -1;
        end
        if (int'(sel) < N && in_valid[sel]) return int'(sel);
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_chan  = 0;
        m_ptr   = 0;
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step();
        int g;
        #1;
        g = model_grant();
        check_eq("in_ready", 32'(in_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        @(posedge clk);
        if (g >= 0) begin
            m_valid = 1'b1;
            m_data  = in_data[g*W +: W];
            m_chan  = g;
            if (RR_BUILT && mode) m_ptr = (g + 1) % N;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        #1;
        check_eq("out_valid", 32'(out_valid), 32'(m_valid));
        check_eq("out_data", 32'(out_data), 32'(m_data));
        check_eq("out_chan", 32'(out_chan), 32'(m_chan));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = '0;
        sel       = '0;
        mode      = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #1;
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_data", 32'(out_data), 32'd0);
        check_eq("rst_chan", 32'(out_chan), 32'd0);
        check_eq("rst_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Select mode, flowing
        sel = 2'd2; in_valid = 4'b0100; in_data = 32'h003C_0000; out_ready = 1'b1;
        #1 check_eq("sel_ready", 32'(in_ready), 32'h4);
        step();
        check_eq("sel_data", 32'(out_data), 32'h3C);
        check_eq("sel_chan", 32'(out_chan), 32'd2);

        // Backpressure: hold 8'h11 while channel 1 waits with 8'h22
        sel = 2'd0; in_valid = 4'b0001; in_data = 32'h0000_0011;
        step();
        out_ready = 1'b0; sel = 2'd1; in_valid = 4'b0010; in_data = 32'h0000_2200;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("bp_hold", 32'(out_data), 32'h11);
        end
        out_ready = 1'b1;
        step();
        check_eq("bp_data", 32'(out_data), 32'h22);
        check_eq("bp_chan", 32'(out_chan), 32'd1);

        // Drain, then invalid select
        in_valid = 4'b0000;
        step();
        sel = 2'd3; in_valid = 4'b0111;
        step();
        check_eq("inv_valid", 32'(out_valid), 32'd0);

        // Round-robin fairness (select mode fallback when not built)
        mode = 1'b1; sel = 2'd1; in_valid = 4'b1111; in_data = 32'h4433_2211;
        for (int k = 0; k < 5; k++) begin
            step();
            check_eq("rr_seq", 32'(out_chan), RR_BUILT ? 32'(k % N) : 32'd1);
        end
        in_valid = 4'b1001;
        step();
        if (RR_BUILT) check_eq("rr_wrap3", 32'(out_chan), 32'd3);
        step();
        if (RR_BUILT) check_eq("rr_wrap0", 32'(out_chan), 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = 4'($urandom);
            sel       = 2'($urandom_range(0, 3));
            mode      = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            step();
        end

        // Asynchronous reset while a word is held
        mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; in_data = 32'h0000_00A5; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        check_eq("hold_a5", 32'(out_data), 32'hA5);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_eq("arst_valid", 32'(out_valid), 32'd0);
        check_eq("arst_data", 32'(out_data), 32'd0);
        check_eq("arst_chan", 32'(out_chan), 32'd0);
        check_eq("arst_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
